// File: rtl/sieve_engine.sv
// Sieve of Eratosthenes engine: builds a prime list up to a runtime limit and
// exposes it through an indexed read port and a valid/ready stream.
module sieve_engine #(
   parameter int N_MAX = 1024,
   parameter int AW    = 10,
   parameter int IDX_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [AW-1:0]    limit,
   output logic             busy,
   output logic             done,
   output logic             overflow,
   output logic [IDX_W:0]   prime_count,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [AW-1:0]    rd_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [AW-1:0]    out_prime,
   output logic             out_last
);

   localparam int LIST_N = 2**IDX_W;

   typedef enum logic [2:0] {
      IDLE, INIT, SCAN_RD, SCAN_CHK, MARK, COL_RD, COL_CHK, DONE
   } state_t;

   state_t          state_r, state_next_s;
   logic [AW-1:0]   lim_r;
   logic [AW-1:0]   a_r;
   logic [AW-1:0]   p_r;
   logic [AW:0]     m_r;
   logic [AW:0]     i_r;
   logic [IDX_W:0]  count_r;
   logic [IDX_W:0]  ptr_r;
   logic            ovf_r;

   logic            flag_mem_r [N_MAX];
   logic            flag_rd_r;
   logic [AW-1:0]   list_r [LIST_N];

   logic [2*AW-1:0] pp_s;
   logic [AW:0]     m_sum_s;
   logic            start_acc_s;
   logic            flag_we_s, flag_wdata_s, flag_re_s;
   logic [AW-1:0]   flag_waddr_s, flag_raddr_s;
   logic            p_init_s, p_inc_s, m_load_s, m_step_s, i_init_s, i_inc_s;
   logic            list_we_s, ovf_set_s;
   logic [IDX_W:0]  ptr_next_s;
   logic            valid_next_s;

   assign pp_s    = {{AW{1'b0}}, p_r} * {{AW{1'b0}}, p_r};
   assign m_sum_s = m_r + {1'b0, p_r};

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode and datapath/memory strobes
   always_comb begin
      state_next_s = state_r;
      start_acc_s  = 1'b0;
      flag_we_s    = 1'b0;
      flag_waddr_s = {AW{1'b0}};
      flag_wdata_s = 1'b0;
      flag_re_s    = 1'b0;
      flag_raddr_s = {AW{1'b0}};
      p_init_s     = 1'b0;
      p_inc_s      = 1'b0;
      m_load_s     = 1'b0;
      m_step_s     = 1'b0;
      i_init_s     = 1'b0;
      i_inc_s      = 1'b0;
      list_we_s    = 1'b0;
      ovf_set_s    = 1'b0;
      case (state_r)
         IDLE, DONE: begin
            if (start) begin
               start_acc_s  = 1'b1;
               state_next_s = INIT;
            end else begin
               state_next_s = state_r;
            end
         end
         INIT: begin
            flag_we_s    = 1'b1;
            flag_waddr_s = a_r;
            flag_wdata_s = (a_r >= AW'(2));
            if (a_r == {AW{1'b1}}) begin
               p_init_s     = 1'b1;
               state_next_s = SCAN_RD;
            end else begin
               state_next_s = INIT;
            end
         end
         SCAN_RD: begin
            if (pp_s > {{AW{1'b0}}, lim_r}) begin
               i_init_s     = 1'b1;
               state_next_s = COL_RD;
            end else begin
               flag_re_s    = 1'b1;
               flag_raddr_s = p_r;
               state_next_s = SCAN_CHK;
            end
         end
         SCAN_CHK: begin
            if (flag_rd_r) begin
               m_load_s     = 1'b1;
               state_next_s = MARK;
            end else begin
               p_inc_s      = 1'b1;
               state_next_s = SCAN_RD;
            end
         end
         MARK: begin
            flag_we_s    = 1'b1;
            flag_waddr_s = m_r[AW-1:0];
            flag_wdata_s = 1'b0;
            if (m_sum_s > {1'b0, lim_r}) begin
               p_inc_s      = 1'b1;
               state_next_s = SCAN_RD;
            end else begin
               m_step_s     = 1'b1;
               state_next_s = MARK;
            end
         end
         COL_RD: begin
            // i is one bit wider than the limit, so i = N_MAX also lands here
            if (i_r > {1'b0, lim_r}) begin
               state_next_s = DONE;
            end else begin
               flag_re_s    = 1'b1;
               flag_raddr_s = i_r[AW-1:0];
               state_next_s = COL_CHK;
            end
         end
         COL_CHK: begin
            i_inc_s      = 1'b1;
            state_next_s = COL_RD;
            if (flag_rd_r) begin
               if (count_r[IDX_W] == 1'b0) begin
                  list_we_s = 1'b1;
               end else begin
                  ovf_set_s = 1'b1;
               end
            end else begin
               list_we_s = 1'b0;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Stream pointer advance and next-cycle valid
   always_comb begin
      ptr_next_s   = ptr_r;
      valid_next_s = 1'b0;
      if (start_acc_s) begin
         ptr_next_s = {(IDX_W+1){1'b0}};
      end else if ((state_r == DONE) && out_valid && out_ready) begin
         ptr_next_s = ptr_r + {{IDX_W{1'b0}}, 1'b1};
      end else begin
         ptr_next_s = ptr_r;
      end
      if (state_next_s == DONE) begin
         valid_next_s = (ptr_next_s < count_r);
      end else begin
         valid_next_s = 1'b0;
      end
   end

   // Sieve datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         lim_r   <= {AW{1'b0}};
         a_r     <= {AW{1'b0}};
         p_r     <= {AW{1'b0}};
         m_r     <= {(AW+1){1'b0}};
         i_r     <= {(AW+1){1'b0}};
         count_r <= {(IDX_W+1){1'b0}};
         ptr_r   <= {(IDX_W+1){1'b0}};
         ovf_r   <= 1'b0;
      end else begin
         ptr_r <= ptr_next_s;
         if (start_acc_s) begin
            lim_r   <= limit;
            a_r     <= {AW{1'b0}};
            count_r <= {(IDX_W+1){1'b0}};
            ovf_r   <= 1'b0;
         end else begin
            if (state_r == INIT) begin
               a_r <= a_r + AW'(1);
            end
            if (list_we_s) begin
               count_r <= count_r + {{IDX_W{1'b0}}, 1'b1};
            end
            if (ovf_set_s) begin
               ovf_r <= 1'b1;
            end
         end
         if (p_init_s) begin
            p_r <= AW'(2);
         end else if (p_inc_s) begin
            p_r <= p_r + AW'(1);
         end
         if (m_load_s) begin
            m_r <= pp_s[AW:0];
         end else if (m_step_s) begin
            m_r <= m_sum_s;
         end
         if (i_init_s) begin
            i_r <= (AW+1)'(2);
         end else if (i_inc_s) begin
            i_r <= i_r + (AW+1)'(1);
         end
      end
   end

   // Flag and prime-list storage (contents are rebuilt by every run)
   always_ff @(posedge clk) begin
      if (flag_we_s) begin
         flag_mem_r[flag_waddr_s] <= flag_wdata_s;
      end
      if (flag_re_s) begin
         flag_rd_r <= flag_mem_r[flag_raddr_s];
      end
      if (list_we_s) begin
         list_r[count_r[IDX_W-1:0]] <= i_r[AW-1:0];
      end
   end

   // Registered status, read port and stream outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_data   <= {AW{1'b0}};
         out_valid <= 1'b0;
         out_prime <= {AW{1'b0}};
         out_last  <= 1'b0;
      end else begin
         busy      <= (state_next_s != IDLE) && (state_next_s != DONE);
         done      <= (state_next_s == DONE);
         rd_data   <= ({1'b0, rd_idx} < count_r) ? list_r[rd_idx] : {AW{1'b0}};
         out_valid <= valid_next_s;
         out_prime <= valid_next_s ? list_r[ptr_next_s[IDX_W-1:0]] : {AW{1'b0}};
         out_last  <= valid_next_s &&
                      (ptr_next_s == (count_r - {{IDX_W{1'b0}}, 1'b1}));
      end
   end

   assign overflow    = ovf_r;
   assign prime_count = count_r;

endmodule

// File: tb/tb_sieve_engine.sv
// Directed self-checking bench for sieve_engine: default build plus a
// small-list build (IDX_W=3) to exercise overflow.
module tb_sieve_engine;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, start_s;
   logic [9:0] limit, limit_s;
   logic       busy, done, overflow;
   logic       busy_s, done_s, overflow_s;
   logic [8:0] prime_count;
   logic [3:0] prime_count_s;
   logic [7:0] rd_idx;
   logic [2:0] rd_idx_s;
   logic [9:0] rd_data, rd_data_s;
   logic       out_valid, out_ready, out_last;
   logic       out_valid_s, out_ready_s, out_last_s;
   logic [9:0] out_prime, out_prime_s;

   int total = 0;
   int bad   = 0;
   int cyc1, cyc2, cyc_tmp;
   int exp_q[$];

   always #5 clk = ~clk;

   sieve_engine #(.N_MAX(1024), .AW(10), .IDX_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .limit(limit),
      .busy(busy), .done(done), .overflow(overflow), .prime_count(prime_count),
      .rd_idx(rd_idx), .rd_data(rd_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_prime(out_prime), .out_last(out_last)
   );

   sieve_engine #(.N_MAX(1024), .AW(10), .IDX_W(3)) dut_s (
      .clk(clk), .rst(rst), .start(start_s), .limit(limit_s),
      .busy(busy_s), .done(done_s), .overflow(overflow_s), .prime_count(prime_count_s),
      .rd_idx(rd_idx_s), .rd_data(rd_data_s),
      .out_valid(out_valid_s), .out_ready(out_ready_s),
      .out_prime(out_prime_s), .out_last(out_last_s)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_start(input bit sel, input int lim);
      if (sel) begin
         limit_s = 10'(lim);
         start_s = 1'b1;
      end else begin
         limit = 10'(lim);
         start = 1'b1;
      end
      tick();
      start   = 1'b0;
      start_s = 1'b0;
   endtask

   task automatic wait_done(input bit sel, input string tag, output int cyc);
      cyc = 0;
      while (((sel ? done_s : done) !== 1'b1) && (cyc < 20000)) begin
         tick();
         cyc++;
      end
      chk({tag, " done"}, sel ? done_s : done, 1);
      chk({tag, " busy"}, sel ? busy_s : busy, 0);
   endtask

   // Drains up to stop_after elements, comparing against exp_q; checks hold
   // stability whenever the previous cycle was a stall.
   task automatic stream_check(input bit sel, input bit toggle, input int stop_after,
                               input string tag);
      int   k = 0;
      bit   stalled = 1'b0;
      logic [9:0] sp = '0;
      logic sl = 1'b0;
      logic v, la, r;
      logic [9:0] pr;
      int   n_exp = exp_q.size();
      for (int cyc = 0; cyc < 300 && k < stop_after; cyc++) begin
         v  = sel ? out_valid_s : out_valid;
         pr = sel ? out_prime_s : out_prime;
         la = sel ? out_last_s  : out_last;
         if (stalled) begin
            chk({tag, " stall valid"}, v, 1);
            chk({tag, " stall prime"}, pr, sp);
            chk({tag, " stall last"}, la, sl);
         end
         r = toggle ? (((cyc / 3) % 2) == 1) : 1'b1;
         if (sel) out_ready_s = r; else out_ready = r;
         if (v && r) begin
            chk({tag, " prime"}, pr, exp_q[k]);
            chk({tag, " last"}, la, (k == n_exp - 1));
            k++;
            stalled = 1'b0;
         end else if (v) begin
            stalled = 1'b1;
            sp = pr;
            sl = la;
         end else begin
            stalled = 1'b0;
         end
         tick();
      end
      chk({tag, " xfers"}, k, stop_after);
      if (stop_after >= n_exp) begin
         chk({tag, " valid after last"}, sel ? out_valid_s : out_valid, 0);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; start_s = 1'b0;
      limit = '0; limit_s = '0; rd_idx = '0; rd_idx_s = '0;
      out_ready = 1'b0; out_ready_s = 1'b0;
      tick(); tick();
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst overflow", overflow, 0);
      chk("rst count", prime_count, 0);
      chk("rst valid", out_valid, 0);
      chk("rst last", out_last, 0);
      chk("rst prime", out_prime, 0);
      chk("rst rd_data", rd_data, 0);
      rst = 1'b0;
      tick();

      // limit=30 baseline
      do_start(0, 30);
      chk("l30 busy next", busy, 1);
      chk("l30 done low", done, 0);
      wait_done(0, "l30", cyc1);
      chk("l30 within 2000", (cyc1 < 2000), 1);
      chk("l30 count", prime_count, 10);
      chk("l30 overflow", overflow, 0);
      exp_q = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29};
      stream_check(0, 0, 10, "l30 stream");

      // full range
      do_start(0, 1023);
      wait_done(0, "l1023", cyc_tmp);
      chk("l1023 count", prime_count, 172);
      chk("l1023 overflow", overflow, 0);
      rd_idx = 8'd171;
      tick();
      chk("rd 171", rd_data, 1021);
      rd_idx = 8'd172;
      tick();
      chk("rd 172", rd_data, 0);
      rd_idx = 8'd0;
      tick();
      chk("rd 0", rd_data, 2);

      // limit=1: empty list, no stream
      out_ready = 1'b1;
      do_start(0, 1);
      wait_done(0, "l1", cyc_tmp);
      chk("l1 count", prime_count, 0);
      for (int j = 0; j < 4; j++) begin
         chk("l1 no valid", out_valid, 0);
         tick();
      end

      // limit=2: single element
      do_start(0, 2);
      wait_done(0, "l2", cyc_tmp);
      chk("l2 count", prime_count, 1);
      exp_q = '{2};
      stream_check(0, 0, 1, "l2 stream");

      // small list overflows
      do_start(1, 30);
      wait_done(1, "small", cyc_tmp);
      chk("small count", prime_count_s, 8);
      chk("small overflow", overflow_s, 1);
      exp_q = '{2, 3, 5, 7, 11, 13, 17, 19};
      stream_check(1, 0, 8, "small stream");

      // back-pressure then restart mid-stream
      out_ready = 1'b0;
      do_start(0, 30);
      wait_done(0, "bp", cyc_tmp);
      exp_q = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29};
      stream_check(0, 1, 5, "bp stream");
      out_ready = 1'b0;
      do_start(0, 10);
      chk("restart valid drop", out_valid, 0);
      chk("restart busy", busy, 1);
      chk("restart done low", done, 0);
      wait_done(0, "l10", cyc_tmp);
      chk("l10 count", prime_count, 4);
      exp_q = '{2, 3, 5, 7};
      stream_check(0, 1, 4, "l10 stream");

      // reset in the middle of marking
      out_ready = 1'b0;
      do_start(0, 500);
      for (int j = 0; j < 1040; j++) tick();
      chk("mid busy", busy, 1);
      rst = 1'b1;
      tick();
      chk("abort busy", busy, 0);
      chk("abort done", done, 0);
      chk("abort overflow", overflow, 0);
      chk("abort count", prime_count, 0);
      chk("abort valid", out_valid, 0);
      chk("abort last", out_last, 0);
      chk("abort prime", out_prime, 0);
      chk("abort rd_data", rd_data, 0);
      rst = 1'b0;
      tick();
      do_start(0, 30);
      chk("rerun busy next", busy, 1);
      wait_done(0, "rerun", cyc2);
      chk("rerun cycles", cyc2, cyc1);
      chk("rerun count", prime_count, 10);
      chk("rerun overflow", overflow, 0);
      exp_q = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29};
      stream_check(0, 0, 10, "rerun stream");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
